axi_r_w2n_data_splitter: RTL

Read-data path of the AXI wide-to-narrow read width converter, the read-direction counterpart of the write narrow-to-wide converter. Accepts one burst command at a time, takes wide R beats from the wide slave side, and emits the corresponding sequence of narrow R beats to the narrow master side. Lane selection follows the burst start address, and RLAST is regenerated from the narrow burst length. A single-entry holding register sustains one narrow beat per clock.

---
 rtl/axi_r_w2n_data_splitter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axi_r_w2n_data_splitter.sv
// AXI read-data wide-to-narrow splitter: one burst at a time, each wide R beat is cut into narrow beats.
// Optional RLAST consistency check is built when AXI_R_W2N_LAST_CHECK_EN is defined.
module axi_r_w2n_data_splitter #(
  parameter int WIDE_DATA_WIDTH   = 64,
  parameter int NARROW_DATA_WIDTH = 32,
  parameter int ID_WIDTH          = 8,
  localparam int RATIO  = WIDE_DATA_WIDTH / NARROW_DATA_WIDTH,
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [LANE_W-1:0]            cmd_lane,
  input  logic [7:0]                   cmd_len,
  input  logic [ID_WIDTH-1:0]          cmd_id,
  input  logic [WIDE_DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]                   s_rresp,
  input  logic                         s_rlast,
  input  logic                         s_rvalid,
  output logic                         s_rready,
  output logic [NARROW_DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]                   m_rresp,
  output logic [ID_WIDTH-1:0]          m_rid,
  output logic                         m_rlast,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  output logic                         err_last
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

  state_t                                   state_r;
  state_t                                   state_next_s;
  logic [LANE_W-1:0]                        lane_r;
  logic [7:0]                               cnt_r;
  logic [7:0]                               len_r;
  logic [ID_WIDTH-1:0]                      id_r;
  logic [WIDE_DATA_WIDTH-1:0]               hold_data_r;
  logic [1:0]                               hold_resp_r;
  logic                                     hold_full_r;
  logic [RATIO-1:0][NARROW_DATA_WIDTH-1:0]  lanes_s;
  logic                                     cmd_hs_s;
  logic                                     m_hs_s;
  logic                                     last_s;
  logic                                     release_s;
  logic                                     final_s;
  logic                                     s_hs_s;

  // Handshake decode; a wide beat is released on its top lane or on the burst's last narrow beat
  always_comb begin
    cmd_hs_s  = cmd_valid && cmd_ready;
    last_s    = hold_full_r && (cnt_r == len_r);
    m_hs_s    = hold_full_r && m_rready;
    release_s = m_hs_s && ((lane_r == LANE_MAX) || last_s);
    final_s   = m_hs_s && last_s;
    s_hs_s    = s_rvalid && s_rready;
  end

  assign cmd_ready = (state_r == IDLE) && !rst;
  assign s_rready  = (state_r == ACTIVE) && (!hold_full_r || release_s) && !final_s;

  assign lanes_s  = hold_data_r;
  assign m_rdata  = lanes_s[lane_r];
  assign m_rresp  = hold_resp_r;
  assign m_rid    = id_r;
  assign m_rlast  = last_s;
  assign m_rvalid = hold_full_r;

  // Burst state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (final_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Command context, narrow beat counters and the single-entry wide holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r      <= '0;
      cnt_r       <= 8'd0;
      len_r       <= 8'd0;
      id_r        <= '0;
      hold_data_r <= '0;
      hold_resp_r <= 2'b00;
      hold_full_r <= 1'b0;
    end else begin
      if (cmd_hs_s) begin
        lane_r <= (RATIO == 1) ? '0 : cmd_lane;
        cnt_r  <= 8'd0;
        len_r  <= cmd_len;
        id_r   <= cmd_id;
      end else if (m_hs_s) begin
        lane_r <= (lane_r == LANE_MAX) ? '0 : lane_r + 1'b1;
        cnt_r  <= cnt_r + 8'd1;
      end
      if (s_hs_s) begin
        hold_data_r <= s_rdata;
        hold_resp_r <= s_rresp;
        hold_full_r <= 1'b1;
      end else if (release_s) begin
        hold_full_r <= 1'b0;
      end
    end
  end

`ifdef AXI_R_W2N_LAST_CHECK_EN
  // beat_end_r is one past the narrow index of the last lane in the next wide beat to arrive
  logic [9:0] beat_end_r;
  logic       err_last_r;

  // Expected RLAST is set on the wide beat whose lane range covers narrow index len
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_end_r <= 10'd0;
      err_last_r <= 1'b0;
    end else begin
      if (cmd_hs_s) begin
        beat_end_r <= 10'(RATIO) - ((RATIO == 1) ? 10'd0 : 10'(cmd_lane));
      end else if (s_hs_s) begin
        beat_end_r <= beat_end_r + 10'(RATIO);
      end
      if (s_hs_s && (s_rlast != ({2'b00, len_r} < beat_end_r))) begin
        err_last_r <= 1'b1;
      end
    end
  end

  assign err_last = err_last_r;
`else
  logic unused_rlast_s;
  assign unused_rlast_s = s_rlast;
  assign err_last = 1'b0;
`endif

endmodule
